mesh_term_tx: RTL and testbench

// - Terminal-side transmit endpoint for one mesh port: the producer end of the pndng/data_out/pop handshake.
// - Buffers packets pushed by the local agent in an f_depth FIFO.
// - Presents the head packet to the router on data_out with pndng high; the router consumes it by pulsing pop.
// - One instance per terminal; rows*2+columns*2 instances ring the mesh.

---
 rtl/mesh_pkg.sv | 30 +++
 rtl/mesh_tx_fifo_mem.sv | 31 +++
 rtl/mesh_term_tx.sv | 84 ++++++++
 tb/tb_mesh_term_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared mesh packet type, header field offsets and defaults
package mesh_pkg;

  localparam int PCKG_SZ = 40;
  localparam int F_DEPTH = 4;
  localparam int CNT_W   = 16;

  typedef logic [PCKG_SZ-1:0] pkt_t;

  // Header layout, MSB first: target row, target column, source id, payload.
  localparam int ROW_W        = 4;
  localparam int COL_W        = 4;
  localparam int SRC_W        = 8;
  localparam int TRGT_ROW_LSB = PCKG_SZ - ROW_W;
  localparam int TRGT_COL_LSB = TRGT_ROW_LSB - COL_W;
  localparam int SRC_ID_LSB   = TRGT_COL_LSB - SRC_W;

  function automatic logic [ROW_W-1:0] pkt_trgt_row(input pkt_t p);
    return p[TRGT_ROW_LSB +: ROW_W];
  endfunction

  function automatic logic [COL_W-1:0] pkt_trgt_col(input pkt_t p);
    return p[TRGT_COL_LSB +: COL_W];
  endfunction

  function automatic logic [SRC_W-1:0] pkt_src_id(input pkt_t p);
    return p[SRC_ID_LSB +: SRC_W];
  endfunction

endpackage

// File: rtl/mesh_tx_fifo_mem.sv
// rtl/mesh_tx_fifo_mem.sv - packet storage array, one write port, async read
module mesh_tx_fifo_mem
  import mesh_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int f_depth = F_DEPTH,
  localparam int aw = $clog2(f_depth)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [aw-1:0]      wr_addr,
  input  logic [pckg_sz-1:0] wr_data,
  input  logic [aw-1:0]      rd_addr,
  output logic [pckg_sz-1:0] rd_data
);

  logic [pckg_sz-1:0] mem [f_depth];

  // Clearing the array makes data_out read 0 straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < f_depth; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mesh_term_tx.sv
// rtl/mesh_term_tx.sv - terminal transmit FIFO driving the pndng/data_out/pop handshake
module mesh_term_tx
  import mesh_pkg::*;
#(
  parameter int pckg_sz = PCKG_SZ,
  parameter int f_depth = F_DEPTH,
  parameter int cnt_w   = CNT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [pckg_sz-1:0]           push_data,
  output logic                         full,
  output logic [$clog2(f_depth+1)-1:0] count,
  input  logic                         pop,
  output logic                         pndng,
  output logic [pckg_sz-1:0]           data_out,
  output logic [cnt_w-1:0]             sent_cnt,
  output logic [cnt_w-1:0]             drop_cnt,
  output logic                         underflow_err
);

  localparam int aw = $clog2(f_depth);
  localparam int cw = $clog2(f_depth + 1);
  localparam logic [aw-1:0] last_ptr = aw'(f_depth - 1);
  localparam logic [cw-1:0] full_cnt = cw'(f_depth);

  logic [aw-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full  = (count == full_cnt);
  assign pndng = (count != '0);

  // A pop on a full FIFO frees a slot in the same edge, so the push is taken.
  assign do_pop  = pop & pndng;
  assign do_push = push & (!full | do_pop);

  mesh_tx_fifo_mem #(
    .pckg_sz (pckg_sz),
    .f_depth (f_depth)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

  // Explicit wrap so non-power-of-two depths work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (do_push && !do_pop) begin
      count <= count + 1'b1;
    end else if (do_pop && !do_push) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_cnt      <= '0;
      drop_cnt      <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (do_pop && !(&sent_cnt)) sent_cnt <= sent_cnt + 1'b1;
      if (push && full && !pop && !(&drop_cnt)) drop_cnt <= drop_cnt + 1'b1;
      if (pop && !pndng) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mesh_term_tx.sv
// tb/tb_mesh_term_tx.sv - directed self-checking bench for mesh_term_tx
module tb_mesh_term_tx;

  localparam int PW = 40;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          push = 1'b0;
  logic [PW-1:0] push_data = '0;
  logic          full;
  logic [2:0]    count;
  logic          pop = 1'b0;
  logic          pndng;
  logic [PW-1:0] data_out;
  logic [CW-1:0] sent_cnt;
  logic [CW-1:0] drop_cnt;
  logic          underflow_err;

  int passed = 0;
  int total  = 0;
  logic [PW-1:0] sb [$];
  logic [PW-1:0] nxt;

  mesh_term_tx #(.pckg_sz(PW), .f_depth(FD), .cnt_w(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_data     (push_data),
    .full          (full),
    .count         (count),
    .pop           (pop),
    .pndng         (pndng),
    .data_out      (data_out),
    .sent_cnt      (sent_cnt),
    .drop_cnt      (drop_cnt),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, clock it, then sample 1ns after the edge.
  task automatic cyc(input logic p, input logic [PW-1:0] d, input logic q);
    push = p;
    push_data = d;
    pop = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    push_data = '0;
    pop = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pndng", 64'(pndng), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_sent", 64'(sent_cnt), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_uf", 64'(underflow_err), 64'd0);
    reset = 1'b0;

    // Ordering: no same-cycle bypass, head visible one cycle after push.
    push = 1'b1; push_data = 40'hA1;
    #1;
    chk("no_bypass", 64'(pndng), 64'd0);
    cyc(1'b1, 40'hA1, 1'b0);
    chk("ord_pndng1", 64'(pndng), 64'd1);
    chk("ord_head1", 64'(data_out), 64'hA1);
    cyc(1'b1, 40'hA2, 1'b0);
    cyc(1'b1, 40'hA3, 1'b0);
    cyc(1'b1, 40'hA4, 1'b0);
    chk("ord_count4", 64'(count), 64'd4);
    chk("ord_head_a1", 64'(data_out), 64'hA1);
    cyc(1'b0, '0, 1'b1);
    chk("ord_head_a2", 64'(data_out), 64'hA2);
    cyc(1'b0, '0, 1'b1);
    chk("ord_head_a3", 64'(data_out), 64'hA3);
    cyc(1'b0, '0, 1'b1);
    chk("ord_head_a4", 64'(data_out), 64'hA4);
    cyc(1'b0, '0, 1'b1);
    chk("ord_pndng0", 64'(pndng), 64'd0);
    chk("ord_sent4", 64'(sent_cnt), 64'd4);

    // Full and drop.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 40'(8'h10 + i), 1'b0);
    chk("full_set", 64'(full), 64'd1);
    cyc(1'b1, 40'h15, 1'b0);
    chk("drop_cnt1", 64'(drop_cnt), 64'd1);
    chk("drop_count", 64'(count), 64'd4);
    chk("drop_head", 64'(data_out), 64'h11);

    // Full with simultaneous push and pop.
    cyc(1'b1, 40'hB5, 1'b1);
    chk("fsim_count", 64'(count), 64'd4);
    chk("fsim_drop", 64'(drop_cnt), 64'd1);
    chk("fsim_full", 64'(full), 64'd1);
    chk("fsim_h12", 64'(data_out), 64'h12);
    cyc(1'b0, '0, 1'b1);
    chk("fsim_h13", 64'(data_out), 64'h13);
    cyc(1'b0, '0, 1'b1);
    chk("fsim_h14", 64'(data_out), 64'h14);
    cyc(1'b0, '0, 1'b1);
    chk("fsim_hb5", 64'(data_out), 64'hB5);
    cyc(1'b0, '0, 1'b1);
    chk("fsim_empty", 64'(pndng), 64'd0);
    chk("fsim_sent", 64'(sent_cnt), 64'd9);

    // Underflow on empty, sticky.
    chk("uf_pre", 64'(underflow_err), 64'd0);
    cyc(1'b0, '0, 1'b1);
    chk("uf_set", 64'(underflow_err), 64'd1);
    chk("uf_count", 64'(count), 64'd0);
    chk("uf_sent", 64'(sent_cnt), 64'd9);
    cyc(1'b0, '0, 1'b0);
    chk("uf_sticky", 64'(underflow_err), 64'd1);

    // Empty with simultaneous push and pop.
    cyc(1'b1, 40'hC0, 1'b1);
    chk("esim_pndng", 64'(pndng), 64'd1);
    chk("esim_data", 64'(data_out), 64'hC0);
    chk("esim_count", 64'(count), 64'd1);
    chk("esim_sent", 64'(sent_cnt), 64'd9);
    cyc(1'b0, '0, 1'b1);
    chk("esim_drain", 64'(count), 64'd0);

    // Wrap: occupancy held at 2 while pointers go round several times.
    sb.push_back(40'hD0); cyc(1'b1, 40'hD0, 1'b0);
    sb.push_back(40'hD1); cyc(1'b1, 40'hD1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      nxt = 40'(64'hE0 + i);
      chk("wrap_head", 64'(data_out), 64'(sb[0]));
      void'(sb.pop_front());
      sb.push_back(nxt);
      cyc(1'b1, nxt, 1'b1);
      chk("wrap_count", 64'(count), 64'd2);
    end
    chk("wrap_tail0", 64'(data_out), 64'(sb[0]));
    cyc(1'b0, '0, 1'b1);
    chk("wrap_tail1", 64'(data_out), 64'(sb[1]));
    cyc(1'b0, '0, 1'b1);
    chk("wrap_empty", 64'(pndng), 64'd0);
    chk("wrap_sent", 64'(sent_cnt), 64'd22);

    // Asynchronous reset mid-traffic with 3 entries, between clock edges.
    cyc(1'b1, 40'hF1, 1'b0);
    cyc(1'b1, 40'hF2, 1'b0);
    cyc(1'b1, 40'hF3, 1'b0);
    chk("mid_count3", 64'(count), 64'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_pndng", 64'(pndng), 64'd0);
    chk("mid_count", 64'(count), 64'd0);
    chk("mid_data", 64'(data_out), 64'd0);
    chk("mid_sent", 64'(sent_cnt), 64'd0);
    chk("mid_drop", 64'(drop_cnt), 64'd0);
    chk("mid_uf", 64'(underflow_err), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_pndng", 64'(pndng), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
